// File: rtl/branchpredictor_param.sv
// Set-associative branch history table: combinational IF/ID/EX lookup, ID-stage
// allocation, EX-stage counter/target training and a set-by-set invalidate sweep.
module branchpredictor_param #(
  parameter int ADDR_W   = 11,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 4,
  parameter int CTR_W    = 2
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                en,
  input  logic                stall,
  input  logic                ctx,
  input  logic                inv_req,
  output logic                busy,
  output logic [SET_BITS-1:0] dbg_clr_idx,
  input  logic [ADDR_W-1:0]   if_pc,
  output logic                if_hit,
  output logic                if_prediction,
  output logic [ADDR_W-1:0]   if_pbt,
  input  logic                id_valid,
  input  logic                id_is_jump,
  input  logic [ADDR_W-1:0]   id_pc,
  input  logic [ADDR_W-1:0]   id_target,
  output logic                id_hit,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic [ADDR_W-1:0]   ex_target,
  input  logic                ex_taken,
  input  logic                ex_compressed,
  output logic                ex_mispredict,
  output logic [ADDR_W-1:0]   ex_redirect
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS + 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                     state;
  logic [SET_BITS-1:0]        clr_idx;
  logic [SETS-1:0][WAY_W-1:0] fifo_ptr;

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [TAG_W-1:0]           tag_q    [SETS][WAYS];
  logic [ADDR_W-1:0]          target_q [SETS][WAYS];
  logic [CTR_W-1:0]           ctr_q    [SETS][WAYS];

  logic [SET_BITS-1:0] if_set, id_set, ex_set;
  logic [TAG_W-1:0]    if_tag, id_tag, ex_tag;

  assign if_set = if_pc[SET_BITS-1:0];
  assign id_set = id_pc[SET_BITS-1:0];
  assign ex_set = ex_pc[SET_BITS-1:0];
  assign if_tag = {ctx, if_pc[ADDR_W-1:SET_BITS]};
  assign id_tag = {ctx, id_pc[ADDR_W-1:SET_BITS]};
  assign ex_tag = {ctx, ex_pc[ADDR_W-1:SET_BITS]};

  logic             if_match, id_match, ex_match;
  logic [WAY_W-1:0] if_way, id_way, ex_way;

  always_comb begin
    if_match = 1'b0;
    id_match = 1'b0;
    ex_match = 1'b0;
    if_way   = '0;
    id_way   = '0;
    ex_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[if_set][w] && (tag_q[if_set][w] == if_tag)) begin
        if_match = 1'b1;
        if_way   = WAY_W'(w);
      end
      if (valid_q[id_set][w] && (tag_q[id_set][w] == id_tag)) begin
        id_match = 1'b1;
        id_way   = WAY_W'(w);
      end
      if (valid_q[ex_set][w] && (tag_q[ex_set][w] == ex_tag)) begin
        ex_match = 1'b1;
        ex_way   = WAY_W'(w);
      end
    end
  end

  // Table contents are meaningless mid-sweep, so every port reports a miss while busy.
  logic ex_hit, ex_pred;

  assign busy          = (state == S_CLEAR);
  assign dbg_clr_idx   = clr_idx;
  assign if_hit        = if_match & ~busy;
  assign if_prediction = if_hit & ctr_q[if_set][if_way][CTR_W-1];
  assign if_pbt        = if_hit ? target_q[if_set][if_way] : '0;
  assign id_hit        = id_match & ~busy;
  assign ex_hit        = ex_match & ~busy;
  assign ex_pred       = ex_hit & ctr_q[ex_set][ex_way][CTR_W-1];

  assign ex_mispredict = ex_valid & ((ex_pred != ex_taken) |
                         (ex_pred & ex_taken & (target_q[ex_set][ex_way] != ex_target)));
  assign ex_redirect   = ex_taken ? ex_target
                                  : ex_pc + (ex_compressed ? ADDR_W'(1) : ADDR_W'(2));

  logic             inv_found;
  logic [WAY_W-1:0] inv_way, victim;

  // Walk downward so the lowest-index invalid way is the one left standing.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[id_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim = inv_found ? inv_way : fifo_ptr[id_set];

  logic idle_go, do_alloc, do_update;

  assign idle_go   = (state == S_IDLE) & en & ~stall & ~inv_req;
  assign do_alloc  = idle_go & id_valid & ~id_hit;
  assign do_update = idle_go & ex_valid & ex_hit &
                     ~(do_alloc & (id_set == ex_set) & (victim == ex_way));

  logic [CTR_W-1:0] ctr_cur, ctr_nxt;

  assign ctr_cur = ctr_q[ex_set][ex_way];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (ex_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
    end else if (ctr_cur != '0) begin
      ctr_nxt = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_idx  <= '0;
      fifo_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inv_req) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
          end
          if (do_alloc && !inv_found) begin
            fifo_ptr[id_set] <= (fifo_ptr[id_set] == WAY_W'(WAYS - 1)) ? '0
                                                                      : fifo_ptr[id_set] + 1'b1;
          end
        end
        S_CLEAR: begin
          fifo_ptr[clr_idx] <= '0;
          if (inv_req) begin
            clr_idx <= '0;
          end else if (clr_idx == SET_BITS'(SETS - 1)) begin
            state <= S_IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Allocation is written last so it overrides an update aimed at the same entry.
  always_ff @(posedge CLK) begin
    if (busy) begin
      valid_q[clr_idx] <= '0;
    end else begin
      if (do_update) begin
        ctr_q[ex_set][ex_way] <= ctr_nxt;
        if (ex_taken) target_q[ex_set][ex_way] <= ex_target;
      end
      if (do_alloc) begin
        valid_q[id_set][victim]  <= 1'b1;
        tag_q[id_set][victim]    <= id_tag;
        target_q[id_set][victim] <= id_target;
        ctr_q[id_set][victim]    <= id_is_jump ? CTR_MAX : CTR_WNT;
      end
    end
  end

endmodule

// File: tb/tb_branchpredictor_param.sv
// Directed bench for branchpredictor_param: reset sweep, allocation/replacement,
// training, same-cycle alloc/update, context isolation and invalidate/reset restarts.
module tb_branchpredictor_param;
  localparam int ADDR_W   = 11;
  localparam int SET_BITS = 4;
  localparam int WAYS     = 4;
  localparam int CTR_W    = 2;
  localparam int SETS     = 16;

  logic                CLK = 1'b0;
  logic                rst, en, stall, ctx, inv_req;
  logic                busy;
  logic [SET_BITS-1:0] dbg_clr_idx;
  logic [ADDR_W-1:0]   if_pc, if_pbt;
  logic                if_hit, if_prediction;
  logic                id_valid, id_is_jump, id_hit;
  logic [ADDR_W-1:0]   id_pc, id_target;
  logic                ex_valid, ex_taken, ex_compressed, ex_mispredict;
  logic [ADDR_W-1:0]   ex_pc, ex_target, ex_redirect;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  branchpredictor_param #(
    .ADDR_W(ADDR_W), .SET_BITS(SET_BITS), .WAYS(WAYS), .CTR_W(CTR_W)
  ) dut (
    .CLK(CLK), .rst(rst), .en(en), .stall(stall), .ctx(ctx), .inv_req(inv_req),
    .busy(busy), .dbg_clr_idx(dbg_clr_idx),
    .if_pc(if_pc), .if_hit(if_hit), .if_prediction(if_prediction), .if_pbt(if_pbt),
    .id_valid(id_valid), .id_is_jump(id_is_jump), .id_pc(id_pc), .id_target(id_target),
    .id_hit(id_hit),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
    .ex_compressed(ex_compressed), .ex_mispredict(ex_mispredict), .ex_redirect(ex_redirect)
  );

  // Clock and reset
  always #50 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe(input string tag, input logic [ADDR_W-1:0] pc, input logic h,
                       input logic p, input logic [ADDR_W-1:0] t);
    if_pc = pc;
    #1;
    ck({tag, ".hit"}, if_hit, h);
    ck({tag, ".pred"}, if_prediction, p);
    ck({tag, ".pbt"}, if_pbt, t);
  endtask

  task automatic alloc(input string tag, input logic [ADDR_W-1:0] pc,
                       input logic [ADDR_W-1:0] tgt, input logic jmp, input logic exp_hit);
    id_valid   = 1'b1;
    id_is_jump = jmp;
    id_pc      = pc;
    id_target  = tgt;
    exp_q.push_back(exp_hit);
    cyc();
    id_valid   = 1'b0;
    id_is_jump = 1'b0;
    #1;
    chk({tag, ".id_hit"}, id_hit);
  endtask

  task automatic ex_step(input string tag, input logic [ADDR_W-1:0] pc,
                         input logic [ADDR_W-1:0] tgt, input logic tk, input logic comp,
                         input logic exp_mis, input logic [ADDR_W-1:0] exp_red);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_taken      = tk;
    ex_compressed = comp;
    exp_q.push_back(exp_mis);
    exp_q.push_back(exp_red);
    #1;
    chk({tag, ".mispredict"}, ex_mispredict);
    chk({tag, ".redirect"}, ex_redirect);
    cyc();
    ex_valid = 1'b0;
  endtask

  task automatic busy_run(input string tag);
    for (int i = 0; i < SETS; i++) begin
      ck($sformatf("%s.busy%0d", tag, i), busy, 1);
      ck($sformatf("%s.if_hit%0d", tag, i), if_hit, 0);
      cyc();
    end
    ck({tag, ".busy_done"}, busy, 0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; ctx = 1'b0; inv_req = 1'b0;
    if_pc = 11'h123; id_valid = 1'b0; id_is_jump = 1'b0; id_pc = '0; id_target = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_target = '0; ex_taken = 1'b0; ex_compressed = 1'b0;

    repeat (3) cyc();
    ck("rst.busy", busy, 1);
    ck("rst.idx", dbg_clr_idx, 0);
    ck("rst.if_hit", if_hit, 0);
    ck("rst.if_pred", if_prediction, 0);
    ck("rst.if_pbt", if_pbt, 0);
    rst = 1'b0;
    busy_run("sweep0");

    // Branch allocate then first training
    alloc("a015", 11'h015, 11'h040, 1'b0, 1'b1);
    probe("a015", 11'h015, 1'b1, 1'b0, 11'h040);
    ex_step("ex015a", 11'h015, 11'h040, 1'b1, 1'b0, 1'b1, 11'h040);
    probe("ctr10", 11'h015, 1'b1, 1'b1, 11'h040);

    // Set 7: jump, invalid-first fill, FIFO eviction
    alloc("a027", 11'h027, 11'h100, 1'b1, 1'b1);
    probe("jmp027", 11'h027, 1'b1, 1'b1, 11'h100);
    alloc("a037", 11'h037, 11'h137, 1'b0, 1'b1);
    alloc("a047", 11'h047, 11'h147, 1'b0, 1'b1);
    alloc("a057", 11'h057, 11'h157, 1'b0, 1'b1);
    probe("keep027", 11'h027, 1'b1, 1'b1, 11'h100);
    alloc("a067", 11'h067, 11'h167, 1'b0, 1'b1);
    probe("evict027", 11'h027, 1'b0, 1'b0, 11'h000);
    probe("keep037", 11'h037, 1'b1, 1'b0, 11'h137);
    alloc("a077", 11'h077, 11'h177, 1'b0, 1'b1);
    probe("evict037", 11'h037, 1'b0, 1'b0, 11'h000);
    probe("keep047", 11'h047, 1'b1, 1'b0, 11'h147);
    probe("keep067", 11'h067, 1'b1, 1'b0, 11'h167);
    probe("keep077", 11'h077, 1'b1, 1'b0, 11'h177);

    // Target retraining and counter saturation on 0x015
    ex_step("retgt", 11'h015, 11'h050, 1'b1, 1'b0, 1'b1, 11'h050);
    probe("retgt", 11'h015, 1'b1, 1'b1, 11'h050);
    ex_step("tk_sat", 11'h015, 11'h050, 1'b1, 1'b0, 1'b0, 11'h050);
    ex_step("nt1", 11'h015, 11'h050, 1'b0, 1'b0, 1'b1, 11'h017);
    probe("ctr10b", 11'h015, 1'b1, 1'b1, 11'h050);
    ex_step("nt2", 11'h015, 11'h050, 1'b0, 1'b0, 1'b1, 11'h017);
    probe("ctr01", 11'h015, 1'b1, 1'b0, 11'h050);
    ex_step("nt3", 11'h015, 11'h050, 1'b0, 1'b0, 1'b0, 11'h017);
    ex_step("nt_sat", 11'h015, 11'h050, 1'b0, 1'b1, 1'b0, 11'h016);
    ex_step("tk1", 11'h015, 11'h050, 1'b1, 1'b0, 1'b1, 11'h050);
    probe("ctr01b", 11'h015, 1'b1, 1'b0, 11'h050);
    ex_step("tk2", 11'h015, 11'h050, 1'b1, 1'b0, 1'b1, 11'h050);
    probe("ctr10c", 11'h015, 1'b1, 1'b1, 11'h050);

    // Fall-through wrap and EX misses
    ex_step("wrap_c", 11'h7FF, 11'h123, 1'b0, 1'b1, 1'b0, 11'h000);
    ex_step("wrap_n", 11'h7FF, 11'h123, 1'b0, 1'b0, 1'b0, 11'h001);
    ex_step("miss_tk", 11'h7FF, 11'h010, 1'b1, 1'b0, 1'b1, 11'h010);

    // Same-cycle allocate (way 1) and update (way 0) in set 5
    id_valid = 1'b1; id_pc = 11'h025; id_target = 11'h0A0;
    ex_valid = 1'b1; ex_pc = 11'h015; ex_target = 11'h060; ex_taken = 1'b1; ex_compressed = 1'b0;
    cyc();
    id_valid = 1'b0; ex_valid = 1'b0;
    probe("dual_alloc", 11'h025, 1'b1, 1'b0, 11'h0A0);
    probe("dual_upd", 11'h015, 1'b1, 1'b1, 11'h060);

    // Fill set 5, then allocate into the way EX is updating
    alloc("a035", 11'h035, 11'h0C0, 1'b0, 1'b1);
    alloc("a045", 11'h045, 11'h0D0, 1'b0, 1'b1);
    id_valid = 1'b1; id_pc = 11'h055; id_target = 11'h0B0;
    ex_valid = 1'b1; ex_pc = 11'h015; ex_target = 11'h070; ex_taken = 1'b1;
    cyc();
    id_valid = 1'b0; ex_valid = 1'b0;
    probe("clash_old", 11'h015, 1'b0, 1'b0, 11'h000);
    probe("clash_new", 11'h055, 1'b1, 1'b0, 11'h0B0);

    // Stall and enable gating
    stall = 1'b1;
    alloc("stall", 11'h0C3, 11'h111, 1'b0, 1'b0);
    stall = 1'b0; en = 1'b0;
    alloc("en_off", 11'h0C3, 11'h111, 1'b0, 1'b0);
    en = 1'b1;
    alloc("en_on", 11'h0C3, 11'h111, 1'b0, 1'b1);

    // Context isolation
    ctx = 1'b1;
    probe("ctx1", 11'h025, 1'b0, 1'b0, 11'h000);
    ctx = 1'b0;
    probe("ctx0", 11'h025, 1'b1, 1'b0, 11'h0A0);

    // Invalidate mid-operation, with an allocate in the request cycle
    inv_req = 1'b1; id_valid = 1'b1; id_pc = 11'h0E9; id_target = 11'h0EE;
    cyc();
    inv_req = 1'b0; id_valid = 1'b0;
    if_pc = 11'h025;
    busy_run("inv");
    probe("inv025", 11'h025, 1'b0, 1'b0, 11'h000);
    probe("inv055", 11'h055, 1'b0, 1'b0, 11'h000);
    probe("inv0C3", 11'h0C3, 1'b0, 1'b0, 11'h000);
    probe("inv0E9", 11'h0E9, 1'b0, 1'b0, 11'h000);
    probe("inv077", 11'h077, 1'b0, 1'b0, 11'h000);

    // Invalidate request during the sweep restarts it
    inv_req = 1'b1;
    cyc();
    inv_req = 1'b0;
    repeat (5) cyc();
    ck("sweep_idx5", dbg_clr_idx, 5);
    inv_req = 1'b1;
    cyc();
    inv_req = 1'b0;
    ck("restart_idx", dbg_clr_idx, 0);
    busy_run("restart");

    // Reset at clear index 9 restarts the sweep
    inv_req = 1'b1;
    cyc();
    inv_req = 1'b0;
    for (int i = 0; i < 40 && dbg_clr_idx != 4'd9; i++) cyc();
    ck("reach_idx9", dbg_clr_idx, 9);
    rst = 1'b1;
    #1;
    ck("rst_mid.idx", dbg_clr_idx, 0);
    ck("rst_mid.busy", busy, 1);
    cyc();
    rst = 1'b0;
    busy_run("rst_mid");

    alloc("post", 11'h015, 11'h040, 1'b0, 1'b1);
    probe("post", 11'h015, 1'b1, 1'b0, 11'h040);

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
